// File: rtl/lsp_cb5_search.sv
// lsp_cb5_search
//   Sequential weighted-error search over the 16-entry LSP codebook 5.
//   For each entry i the block computes
//     d = target - cb[i]            (33-bit signed, Q15.16)
//     s = (d*d) >> 16               (Q15.16, reduced to 32 bits)
//     e = (s*weight) >> 16          (Q15.16, reduced to 32 bits)
//   and tracks the lowest e (unsigned) and its index. Ties keep the lowest index.
//   Each entry takes four cycles (DIFF, SQR, WGT, CMP), and a DONE cycle follows
//   the last entry. done_search goes high 65 rising edges after start is sampled.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start_search one-cycle request, only sampled in IDLE
//   target       Q15.16 signed LSP value, held stable while busy
//   weight       Q15.16 non-negative error weight, held stable while busy
//   cb_addr      codebook ROM address (the current entry, 0 in IDLE/DONE)
//   cb_data      codebook ROM data, combinational from cb_addr
//   best_index   index of the minimum-error entry
//   best_error   minimum weighted error
//   busy         search in progress
//   done_search  one-cycle completion pulse
//
// Configuration
//   CB5_ERR_SAT_EN  when defined, s and e saturate to 0x7FFFFFFF if the shifted
//                   result does not fit in 32 bits. When undefined they wrap to
//                   the low 32 bits.

module lsp_cb5_search (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_search,
    input  logic [31:0] target,
    input  logic [31:0] weight,
    output logic [3:0]  cb_addr,
    input  logic [31:0] cb_data,
    output logic [3:0]  best_index,
    output logic [31:0] best_error,
    output logic        busy,
    output logic        done_search
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIFF = 3'd1,
        S_SQR  = 3'd2,
        S_WGT  = 3'd3,
        S_CMP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         i_q, i_d;
    logic signed [32:0] d_q, d_d;
    logic [31:0]        s_q, s_d;
    logic [31:0]        e_q, e_d;
    logic [3:0]         best_index_q, best_index_d;
    logic [31:0]        best_error_q, best_error_d;
    logic               done_q, done_d;

    // Datapath: full-width products, then shift and reduce to 32 bits.
    logic signed [32:0] diff_w;
    logic signed [65:0] d_ext;
    logic signed [65:0] sq_full;
    logic [63:0]        we_full;
    logic [31:0]        s_next;
    logic [31:0]        e_next;

    always_comb begin
        diff_w  = $signed({target[31], target}) - $signed({cb_data[31], cb_data});
        d_ext   = {{33{d_q[32]}}, d_q};
        sq_full = d_ext * d_ext;
        we_full = {32'd0, s_q} * {32'd0, weight};
`ifdef CB5_ERR_SAT_EN
        s_next = ($unsigned(sq_full >> 16) > 66'h0_FFFF_FFFF) ? 32'h7FFF_FFFF
                                                               : 32'($unsigned(sq_full >> 16));
        e_next = ((we_full >> 16) > 64'h0000_0000_FFFF_FFFF) ? 32'h7FFF_FFFF
                                                              : 32'(we_full >> 16);
`else
        s_next = 32'($unsigned(sq_full >> 16));
        e_next = 32'(we_full >> 16);
`endif
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        d_d          = d_q;
        s_d          = s_q;
        e_d          = e_q;
        best_index_d = best_index_q;
        best_error_d = best_error_q;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_search) begin
                    state_d = S_DIFF;
                    i_d     = 4'd0;
                end
            end
            S_DIFF: begin
                d_d     = diff_w;
                state_d = S_SQR;
            end
            S_SQR: begin
                s_d     = s_next;
                state_d = S_WGT;
            end
            S_WGT: begin
                e_d     = e_next;
                state_d = S_CMP;
            end
            S_CMP: begin
                // Entry 0 always loads, which stands in for clearing the running minimum.
                if ((i_q == 4'd0) || (e_q < best_error_q)) begin
                    best_error_d = e_q;
                    best_index_d = i_q;
                end
                if (i_q == 4'd15) begin
                    i_d     = 4'd0;
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 4'd1;
                    state_d = S_DIFF;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                i_d     = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            d_q          <= '0;
            s_q          <= '0;
            e_q          <= '0;
            best_index_q <= '0;
            best_error_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            d_q          <= d_d;
            s_q          <= s_d;
            e_q          <= e_d;
            best_index_q <= best_index_d;
            best_error_q <= best_error_d;
            done_q       <= done_d;
        end
    end

    assign cb_addr     = ((state_q == S_IDLE) || (state_q == S_DONE)) ? 4'd0 : i_q;
    assign best_index  = best_index_q;
    assign best_error  = best_error_q;
    assign busy        = (state_q != S_IDLE);
    assign done_search = done_q;

endmodule

// File: tb/tb_lsp_cb5_search.sv
module tb_lsp_cb5_search;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_search = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] weight = '0;
    logic [3:0]  cb_addr;
    logic [31:0] cb_data;
    logic [3:0]  best_index;
    logic [31:0] best_error;
    logic        busy;
    logic        done_search;

    logic [31:0] cb_rom [16];
    int          checks = 0;
    int          errors = 0;

    assign cb_data = cb_rom[cb_addr];

    always #5 clk = ~clk;

    lsp_cb5_search dut (
        .clk         (clk),
        .rst         (rst),
        .start_search(start_search),
        .target      (target),
        .weight      (weight),
        .cb_addr     (cb_addr),
        .cb_data     (cb_data),
        .best_index  (best_index),
        .best_error  (best_error),
        .busy        (busy),
        .done_search (done_search)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: reduce a shifted product to 32 bits.
    function automatic logic [31:0] reduce32(input logic [127:0] v);
`ifdef CB5_ERR_SAT_EN
        if (v > 128'hFFFF_FFFF) return 32'h7FFF_FFFF;
`endif
        return v[31:0];
    endfunction

    function automatic logic [31:0] entry_err(input logic [31:0] t, input logic [31:0] c,
                                              input logic [31:0] w);
        longint      diff;
        longint      mag;
        logic [31:0] s;
        diff = longint'($signed(t)) - longint'($signed(c));
        mag  = (diff < 0) ? -diff : diff;
        s    = reduce32((128'(mag) * 128'(mag)) >> 16);
        return reduce32((128'(s) * 128'(w)) >> 16);
    endfunction

    // Reference search: first strictly-smaller error wins.
    task automatic model(input logic [31:0] t, input logic [31:0] w,
                         output logic [3:0] idx, output logic [31:0] err);
        logic [31:0] e;
        idx = 4'd0;
        err = entry_err(t, cb_rom[0], w);
        for (int k = 1; k < 16; k++) begin
            e = entry_err(t, cb_rom[k], w);
            if (e < err) begin
                err = e;
                idx = 4'(k);
            end
        end
    endtask

    // Caller is positioned #1 after a rising edge; that next edge is edge 0.
    task automatic run_search(input string tag, input logic [31:0] t, input logic [31:0] w,
                              input int extra_at, input logic [3:0] exp_idx,
                              input logic [31:0] exp_err);
        int first;
        int pulses;
        first  = -1;
        pulses = 0;
        target = t;
        weight = w;
        start_search = 1'b1;
        @(posedge clk); #1;
        start_search = 1'b0;
        check({tag, "/busy"}, 32'(busy), 32'd1);
        for (int n = 1; n <= 70; n++) begin
            if (n == extra_at) start_search = 1'b1;
            @(posedge clk); #1;
            start_search = 1'b0;
            if (done_search) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        check({tag, "/latency"}, 32'(first), 32'd65);
        check({tag, "/pulses"}, 32'(pulses), 32'd1);
        check({tag, "/idle"}, 32'(busy), 32'd0);
        check({tag, "/index"}, 32'(best_index), 32'(exp_idx));
        check({tag, "/error"}, best_error, exp_err);
    endtask

    function automatic logic [31:0] rand_q(input int mode);
        logic [31:0] v;
        case (mode)
            0:       v = $urandom;
            1:       v = 32'((int'($urandom_range(0, 8191)) - 4096) <<< 16) | 32'($urandom_range(0, 65535));
            default: v = 32'(int'($urandom_range(0, 3)) * 50) << 16;
        endcase
        return v;
    endfunction

    initial begin
        logic [3:0]  m_idx;
        logic [31:0] m_err;
        int          pulses;
        int          mode;

        for (int k = 0; k < 16; k++) cb_rom[k] = 32'(1100 + 100 * k) << 16;

        repeat (3) @(posedge clk);
        #1;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done_search), 32'd0);
        check("rst/addr", 32'(cb_addr), 32'd0);
        check("rst/index", 32'(best_index), 32'd0);
        check("rst/error", best_error, 32'd0);

        // First edge after release must accept the start.
        rst = 1'b1;
        run_search("t1100", 32'h044C_0000, 32'h0001_0000, -1, 4'd0, 32'h0000_0000);
        run_search("t1800", 32'h0708_0000, 32'h0001_0000, -1, 4'd7, 32'h0000_0000);
        run_search("tie1850", 32'h073A_0000, 32'h0001_0000, -1, 4'd7, 32'h09C4_0000);
`ifdef CB5_ERR_SAT_EN
        run_search("ovf3000", 32'h0BB8_0000, 32'h0001_0000, -1, 4'd0, 32'h7FFF_FFFF);
`else
        model(32'h0BB8_0000, 32'h0001_0000, m_idx, m_err);
        run_search("ovf3000", 32'h0BB8_0000, 32'h0001_0000, -1, m_idx, m_err);
`endif
        run_search("extra_start", 32'h0708_0000, 32'h0001_0000, 10, 4'd7, 32'h0000_0000);

        // Reset in the middle of a search.
        target = 32'h073A_0000;
        weight = 32'h0001_0000;
        start_search = 1'b1;
        @(posedge clk); #1;
        start_search = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/done", 32'(done_search), 32'd0);
        check("midrst/addr", 32'(cb_addr), 32'd0);
        check("midrst/index", 32'(best_index), 32'd0);
        check("midrst/error", best_error, 32'd0);
        pulses = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            if (n == 2) rst = 1'b1;
            if (done_search) pulses++;
        end
        check("midrst/nodone", 32'(pulses), 32'd0);
        check("midrst/idle", 32'(busy), 32'd0);

        for (int r = 0; r < 12; r++) begin
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < 16; k++) cb_rom[k] = rand_q(mode);
            target = rand_q(mode);
            weight = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h0004_0000));
            model(target, weight, m_idx, m_err);
            run_search($sformatf("rand%0d", r), target, weight, -1, m_idx, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsp_cb5_search.md
LSP_CB5_SEARCH -- requirements
Module: lsp_cb5_search

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 start_search  input  1  one-cycle request; sampled only in IDLE.
REQ-004 target  input  32  LSP value to quantise, signed Q15.16 (1 sign, 15 integer, 16 fraction bits); held stable while busy.
REQ-005 weight  input  32  non-negative Q15.16 error weight; held stable while busy.
REQ-006 cb_addr  output  4  codebook-5 ROM address, driven to the ROM's addr port.
REQ-007 cb_data  input  32  codebook-5 ROM data, combinational from cb_addr, Q15.16.
REQ-008 best_index  output  4  index of minimum-error entry.
REQ-009 best_error  output  32  minimum weighted error, Q15.16.
REQ-010 busy  output  1  high from the cycle after start is accepted until done_search.
REQ-011 done_search  output  1  one-cycle pulse; best_index/best_error valid from this cycle until the next accepted start.

Function
REQ-012 FSM states SHALL be IDLE, DIFF, SQR, WGT, CMP, DONE; 4-bit entry counter i.
- IDLE->DIFF on start_search=1 (i=0, running minimum cleared).
- DIFF->SQR->WGT->CMP: one cycle each.
- CMP->DIFF if i<15 (i increments); CMP->DONE if i==15; DONE->IDLE.
REQ-013 cb_addr SHALL equal i in all states and 0 in IDLE/DONE.
REQ-014 DIFF: register d = target - cb_data as 33-bit signed.
REQ-015 SQR: register s = (d*d)>>16; WGT: register e = (s*weight)>>16, reduced to 32 bits per REQ-024.
REQ-016 CMP: if i==0 or e < current best (unsigned compare), update best_error=e and best_index=i; equality SHALL NOT update, so ties resolve to the lowest index.
REQ-017 Latency: done_search SHALL be high exactly 65 rising edges after the edge at which start_search was sampled (16 entries x 4 cycles + DONE).
REQ-018 start_search while busy or in DONE SHALL be ignored with no effect on the running search.
REQ-019 best_index/best_error SHALL be updated only during CMP and SHALL otherwise hold their values.
REQ-020 Arithmetic SHALL use full-width intermediate products (66-bit for d*d, 64-bit for s*weight) before shifting.

Reset
REQ-021 rst=0 SHALL immediately force IDLE, i=0, cb_addr=0, best_index=0, best_error=0, busy=0, done_search=0, d=s=e=0.
REQ-022 Reset asserted mid-search SHALL abort the search with no done_search pulse; the next search requires a fresh start_search after reset is released.
REQ-023 The first rising edge after rst deasserts SHALL be able to accept start_search.

Configuration
REQ-024 Macro CB5_ERR_SAT_EN: when defined, s and e SHALL saturate to 0x7FFFFFFF when the shifted result exceeds 32 bits; when undefined, s and e SHALL keep the low 32 bits (wrap) and no saturation logic is built.

Verification
REQ-025 target=0x044C0000 (1100.0), weight=0x00010000 -> best_index=0, best_error=0, done_search at edge 65.
REQ-026 target=0x07080000 (1800.0), weight=0x00010000 -> best_index=7, best_error=0.
REQ-027 target=0x073A0000 (1850.0), weight=0x00010000 -> tie between entries 7 and 8 (error 2500 each) -> best_index=7, best_error=0x09C40000.
REQ-028 Overflow case, CB5_ERR_SAT_EN defined: target=0x0BB80000 (3000.0), weight=0x00010000 -> every error saturates to 0x7FFFFFFF, so no entry beats entry 0 -> best_index=0, best_error=0x7FFFFFFF.
REQ-029 Overflow case, CB5_ERR_SAT_EN undefined: same stimulus -> result follows 32-bit wrap of s and e per REQ-024.
REQ-030 Busy/reset robustness: start at edge 0, extra start pulse at edge 10 -> single done_search at edge 65. Separately, rst=0 at edge 30 -> all outputs 0 immediately and no done_search pulse afterwards.
